// File: rtl/axis_seq_pkg.sv
// Shared types and constants for the axis phase sequencer.
package axis_seq_pkg;

  localparam int VEL_W       = 32;
  localparam int POS_W       = 16;
  localparam int AXIS_IDX_W  = 8;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_BADCMD  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Motion-sample strobe: one-cycle tick every CLK_DIV clocks while run is high.
module sample_tick_gen
  import axis_seq_pkg::*;
#(
  parameter int CLK_DIV = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/axis_phase_sequencer.sv
// Per-sample four-phase enable sequencer for NUM_AXES speed axes, with
// shadowed velocity commands, set-position requests and sticky error flags.
module axis_phase_sequencer
  import axis_seq_pkg::*;
#(
  parameter int NUM_AXES = 4,
  parameter int CLK_DIV  = 2000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_axis,
  input  logic [31:0]               cmd_velocity,
  input  logic                      pos_valid,
  output logic                      pos_ready,
  input  logic [7:0]                pos_axis,
  input  logic [15:0]               pos_value,
  input  logic [NUM_AXES-1:0]       in_motion,
  output logic [NUM_AXES-1:0]       ph1,
  output logic [NUM_AXES-1:0]       ph2,
  output logic [NUM_AXES-1:0]       ph3,
  output logic [NUM_AXES-1:0]       ph4,
  output logic [32*NUM_AXES-1:0]    target_velocity,
  output logic [NUM_AXES-1:0]       set_pos_en,
  output logic [15:0]               set_pos_pos,
  output logic                      busy,
  output logic [1:0]                err,
  input  logic                      err_clr
);

  localparam logic [AXIS_IDX_W-1:0] LAST_AXIS = AXIS_IDX_W'(NUM_AXES - 1);

  seq_state_e                  state_q, state_d;
  logic [AXIS_IDX_W-1:0]       a_q, a_d;
  logic [VEL_W*NUM_AXES-1:0]   shadow_q, shadow_d;
  logic [VEL_W*NUM_AXES-1:0]   tgt_q, tgt_d;
  logic                        rdy_q;
  logic [NUM_AXES-1:0]         spe_q, spe_d;
  logic [POS_W-1:0]            spp_q, spp_d;
  logic [1:0]                  err_q, err_d;

  logic                        tick;
  logic                        commit;
  logic [NUM_AXES-1:0]         axis_sel, cmd_sel, pos_sel;
  logic                        cmd_acc, pos_acc, pos_ok, bad_req, overrun;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          commit  = 1'b1;
          a_d     = '0;
          state_d = ST_PH1;
        end
      end
      ST_PH1: state_d = ST_PH2;
      ST_PH2: state_d = ST_PH3;
      ST_PH3: state_d = ST_PH4;
      ST_PH4: begin
        if (a_q == LAST_AXIS) begin
          state_d = ST_IDLE;
        end else begin
          a_d     = a_q + AXIS_IDX_W'(1);
          state_d = ST_PH1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Index decodes done as compares so out-of-range indices simply match nothing.
  always_comb begin
    axis_sel = '0;
    cmd_sel  = '0;
    pos_sel  = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      axis_sel[i] = (a_q == AXIS_IDX_W'(i));
      cmd_sel[i]  = (cmd_axis == AXIS_IDX_W'(i));
      pos_sel[i]  = (pos_axis == AXIS_IDX_W'(i));
    end
  end

  always_comb begin
    cmd_acc  = cmd_valid && rdy_q;
    pos_acc  = pos_valid && pos_ready;
    pos_ok   = (|pos_sel) && !(|(pos_sel & in_motion));
    overrun  = tick && (state_q != ST_IDLE);
    bad_req  = (cmd_acc && !(|cmd_sel)) || (pos_acc && !pos_ok);

    shadow_d = shadow_q;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (cmd_acc && cmd_sel[i]) shadow_d[VEL_W*i +: VEL_W] = cmd_velocity;
    end

    // Commit reads the registered shadow, so a same-cycle command waits a sample.
    tgt_d = commit ? shadow_q : tgt_q;

    spe_d = (pos_acc && pos_ok) ? pos_sel : '0;
    spp_d = (pos_acc && pos_ok) ? pos_value : spp_q;

    err_d = err_clr ? 2'b00 : err_q;
    if (overrun) err_d[ERR_OVERRUN] = 1'b1;
    if (bad_req) err_d[ERR_BADCMD]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      shadow_q <= '0;
      tgt_q    <= '0;
      rdy_q    <= 1'b0;
      spe_q    <= '0;
      spp_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      rdy_q    <= 1'b1;
      spe_q    <= spe_d;
      spp_q    <= spp_d;
      err_q    <= err_d;
    end
  end

  assign ph1             = (state_q == ST_PH1) ? axis_sel : '0;
  assign ph2             = (state_q == ST_PH2) ? axis_sel : '0;
  assign ph3             = (state_q == ST_PH3) ? axis_sel : '0;
  assign ph4             = (state_q == ST_PH4) ? axis_sel : '0;
  assign target_velocity = tgt_q;
  assign set_pos_en      = spe_q;
  assign set_pos_pos     = spp_q;
  assign err             = err_q;
  assign cmd_ready       = rdy_q;
  assign pos_ready       = rdy_q && (state_q == ST_IDLE) && !tick;
  // The commit cycle counts as busy: the sample is already claimed.
  assign busy            = (state_q != ST_IDLE) || tick;

endmodule

// File: tb/tb_axis_phase_sequencer.sv
// Bench for axis_phase_sequencer: directed scenarios plus random traffic
// compared every cycle against a sample-level reference model.
module tb_axis_phase_sequencer;

  localparam int NA  = 4;
  localparam int CD  = 40;
  localparam int CD2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, run, cmd_valid, pos_valid, err_clr;
  logic [7:0]   cmd_axis, pos_axis;
  logic [31:0]  cmd_velocity;
  logic [15:0]  pos_value;
  logic [NA-1:0] in_motion;
  logic         cmd_ready, pos_ready, busy;
  logic [NA-1:0] ph1, ph2, ph3, ph4, set_pos_en;
  logic [32*NA-1:0] target_velocity;
  logic [15:0]  set_pos_pos;
  logic [1:0]   err;

  logic         run2, cmd_valid2, pos_valid2, err_clr2;
  logic [7:0]   cmd_axis2;
  logic         cmd_ready_2, pos_ready_2, busy_2;
  logic [NA-1:0] ph1_2, ph2_2, ph3_2, ph4_2, set_pos_en_2;
  logic [32*NA-1:0] target_velocity_2;
  logic [15:0]  set_pos_pos_2;
  logic [1:0]   err_2;

  axis_phase_sequencer #(.NUM_AXES(NA), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis), .cmd_velocity(cmd_velocity),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_axis(pos_axis), .pos_value(pos_value),
    .in_motion(in_motion), .ph1(ph1), .ph2(ph2), .ph3(ph3), .ph4(ph4),
    .target_velocity(target_velocity), .set_pos_en(set_pos_en), .set_pos_pos(set_pos_pos),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  axis_phase_sequencer #(.NUM_AXES(NA), .CLK_DIV(CD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready_2), .cmd_axis(cmd_axis2), .cmd_velocity(cmd_velocity),
    .pos_valid(pos_valid2), .pos_ready(pos_ready_2), .pos_axis(pos_axis), .pos_value(pos_value),
    .in_motion(in_motion), .ph1(ph1_2), .ph2(ph2_2), .ph3(ph3_2), .ph4(ph4_2),
    .target_velocity(target_velocity_2), .set_pos_en(set_pos_en_2), .set_pos_pos(set_pos_pos_2),
    .busy(busy_2), .err(err_2), .err_clr(err_clr2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: cycles since run, position within the 4*NA phase train.
  int          m_cnt, m_seq;
  bit          m_rdy;
  logic [31:0] m_shad [NA];
  logic [31:0] m_tgt  [NA];
  logic [1:0]  m_err;
  logic [NA-1:0] m_spe;
  logic [15:0] m_spp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tick();
    return (run === 1'b1) && (m_cnt == CD - 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_seq = -1; m_rdy = 0; m_err = '0; m_spe = '0; m_spp = '0;
    for (int i = 0; i < NA; i++) begin m_shad[i] = '0; m_tgt[i] = '0; end
  endtask

  task automatic check_all();
    logic [NA-1:0] e [4];
    logic [127:0] et;
    bit tk;
    tk = m_tick();
    for (int k = 0; k < 4; k++) e[k] = '0;
    if (m_seq >= 0) e[m_seq % 4] = NA'(1) << (m_seq / 4);
    et = '0;
    for (int i = 0; i < NA; i++) et[32*i +: 32] = m_tgt[i];
    chk("ph1", ph1, e[0]);
    chk("ph2", ph2, e[1]);
    chk("ph3", ph3, e[2]);
    chk("ph4", ph4, e[3]);
    chk("busy", busy, (m_seq >= 0) || tk);
    chk("pos_ready", pos_ready, m_rdy && (m_seq < 0) && !tk);
    if (m_rdy) chk("cmd_ready", cmd_ready, 1'b1);
    chk("set_pos_en", set_pos_en, m_spe);
    if (m_spe != '0) chk("set_pos_pos", set_pos_pos, m_spp);
    chk("err", err, m_err);
    chk("target_velocity", target_velocity, et);
  endtask

  task automatic model_advance();
    bit tk, pr;
    logic [1:0] nerr;
    tk = m_tick();
    pr = m_rdy && (m_seq < 0) && !tk;
    nerr = '0;
    if (tk && m_seq >= 0) nerr[1] = 1'b1;
    if (m_seq >= 0) m_seq = (m_seq == 4*NA - 1) ? -1 : m_seq + 1;
    else if (tk) begin
      for (int i = 0; i < NA; i++) m_tgt[i] = m_shad[i];
      m_seq = 0;
    end
    m_cnt = ((run === 1'b1) && m_cnt != CD - 1) ? m_cnt + 1 : 0;
    if (cmd_valid && m_rdy) begin
      if (cmd_axis < NA) m_shad[cmd_axis] = cmd_velocity;
      else nerr[0] = 1'b1;
    end
    m_spe = '0;
    if (pos_valid && pr) begin
      if (pos_axis < NA && !in_motion[pos_axis[1:0]]) begin
        m_spe = NA'(1) << pos_axis;
        m_spp = pos_value;
      end else nerr[0] = 1'b1;
    end
    m_err = (err_clr ? 2'b00 : m_err) | nerr;
    m_rdy = 1;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 0; cmd_axis = '0; cmd_velocity = '0;
    pos_valid = 0; pos_axis = '0; pos_value = '0; in_motion = '0; err_clr = 0;
  endtask

  task automatic wait_seq(input int target, input int limit);
    int n = 0;
    while (m_seq != target && n < limit) begin step(); n++; end
    chk("wait_seq_timeout", n < limit, 1'b1);
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    while (!m_tick() && n < limit) begin step(); n++; end
    chk("wait_tick_timeout", n < limit, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, np;
    logic [15:0] m100;
    m100 = 16'hFFFF - 16'd99;
    rst_n = 0; run = 0; idle_in();
    run2 = 0; cmd_valid2 = 0; cmd_axis2 = '0; pos_valid2 = 0; err_clr2 = 0;
    model_reset();
    #2;
    chk("rst_phases", {ph1, ph2, ph3, ph4}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pos_ready", pos_ready, 1'b0);
    chk("rst_outputs", {target_velocity, set_pos_en, set_pos_pos, err}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    step();

    // Set-position accepted, then rejected because the axis is moving.
    pos_valid = 1; pos_axis = 8'd1; pos_value = m100; in_motion = '0;
    step();
    idle_in();
    chk("setpos_en", set_pos_en, 4'b0010);
    chk("setpos_val", set_pos_pos, 16'hFF9C);
    step();
    pos_valid = 1; pos_axis = 8'd1; pos_value = 16'h1234; in_motion = 4'b0010;
    step();
    idle_in();
    chk("setpos_moving_en", set_pos_en, 4'b0000);
    chk("setpos_moving_err", err, 2'b01);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_cleared", err, 2'b00);

    // Short-divider instance: overrun, clear, bad command racing a clear.
    run2 = 1;
    repeat (35) step();
    chk("dut2_overrun", err_2, 2'b10);
    run2 = 0;
    repeat (20) step();
    err_clr2 = 1;
    step();
    err_clr2 = 0;
    chk("dut2_err_clr", err_2, 2'b00);
    cmd_valid2 = 1; cmd_axis2 = 8'd7; err_clr2 = 1;
    step();
    cmd_valid2 = 0; err_clr2 = 0;
    chk("dut2_badcmd_wins", err_2, 2'b01);
    chk("dut2_idle", {busy_2, ph1_2, ph2_2, ph3_2, ph4_2, set_pos_en_2}, '0);
    chk("dut2_ready", {cmd_ready_2, pos_ready_2}, 2'b11);
    chk("dut2_data", {target_velocity_2, set_pos_pos_2}, '0);
    err_clr = 1;
    step();
    err_clr = 0;

    // One full sample: busy span and phase pulse count.
    run = 1;
    wait_tick(100, n);
    chk("first_tick_delay", n, CD - 1);
    nb = 0; np = 0;
    repeat (CD) begin
      if (busy) nb++;
      np += $countones({ph1, ph2, ph3, ph4});
      step();
    end
    chk("busy_cycles", nb, 17);
    chk("phase_pulses", np, 16);

    // Velocity command mid-sequence, then one landing in the commit cycle.
    wait_seq(5, 60);
    cmd_valid = 1; cmd_axis = 8'd2; cmd_velocity = 32'h0010_0000;
    step();
    idle_in();
    chk("vel_mid_seq", target_velocity[95:64], 32'h0);
    wait_tick(60, n);
    cmd_valid = 1; cmd_axis = 8'd2; cmd_velocity = 32'h1234_5678;
    step();
    idle_in();
    chk("vel_committed", target_velocity[95:64], 32'h0010_0000);
    wait_tick(60, n);
    step();
    chk("vel_delayed", target_velocity[95:64], 32'h1234_5678);

    // run dropped mid-sequence: the train completes, then no more ticks.
    wait_seq(2, 60);
    run = 0;
    repeat (30) step();
    run = 1;

    repeat (400) begin
      cmd_valid    = ($urandom_range(0, 3) == 0);
      cmd_axis     = 8'($urandom_range(0, 5));
      cmd_velocity = $urandom;
      pos_valid    = ($urandom_range(0, 4) == 0);
      pos_axis     = 8'($urandom_range(0, 4));
      pos_value    = 16'($urandom);
      in_motion    = NA'($urandom & $urandom);
      err_clr      = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_in();

    // Reset in PH3 of axis 1 aborts immediately.
    wait_seq(6, 200);
    rst_n = 0;
    #1;
    chk("abort_phases", {ph1, ph2, ph3, ph4}, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_pos_ready", pos_ready, 1'b0);
    chk("abort_outputs", {target_velocity, set_pos_en, set_pos_pos, err}, '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    wait_tick(100, n);
    chk("post_reset_tick_delay", n, CD - 1);
    step();
    chk("post_reset_ph1", ph1, 4'b0001);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
